// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port arbiter bus.
// Bundles the two requester handshakes (A: CPU writeback, B: debug/loader)
// together with the arbitrated register-file write port.
//   master : requester side, drives valid/addr/data, observes ready and write port
//   slave  : arbiter side, drives ready, WE3/WA3/WD3 and init_done
interface rf_write_arbiter_if #(
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  a_valid;
    logic [ADDR_SIZE-1:0]  a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_ready;

    logic                  b_valid;
    logic [ADDR_SIZE-1:0]  b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_ready;

    logic                  WE3;
    logic [ADDR_SIZE-1:0]  WA3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  init_done;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  WE3, WA3, WD3, init_done
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output WE3, WA3, WD3, init_done
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner.
// After reset it clears every register to zero (optional), then shares the single
// write port between port A (CPU writeback) and port B (debug/loader) using
// valid/ready handshakes and round-robin arbitration. WE3/WA3/WD3 are registered
// on posedge CLK so they are stable when the register file samples on negedge.
// Ports:
//   CLK    : clock, all state changes on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of rf_write_arbiter_if (requests, readies, write port,
//            init_done)
module rf_write_arbiter #(
    parameter int unsigned ADDR_SIZE      = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                CLK,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {StClear, StRun} state_e;
    typedef enum logic [0:0] {GrantA, GrantB} grant_e;

    localparam state_e               ResetState = CLEAR_ON_RESET ? StClear : StRun;
    localparam logic [ADDR_SIZE-1:0] LastAddr   = '1;

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic [ADDR_SIZE-1:0]  clr_cnt_q, clr_cnt_d;
    logic                  we3_q, we3_d;
    logic [ADDR_SIZE-1:0]  wa3_q, wa3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
    logic                  init_done_q, init_done_d;
    logic                  a_ready, b_ready;

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CLEAR leaves once the last address has been issued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_cnt_q == LastAddr) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = ResetState;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        last_grant_d = last_grant_q;
        clr_cnt_d    = clr_cnt_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        init_done_d  = init_done_q;

        unique case (state_q)
            StClear: begin
                we3_d     = 1'b1;
                wa3_d     = clr_cnt_q;
                wd3_d     = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) init_done_d = 1'b1;
            end
            StRun: begin
                init_done_d = 1'b1;
                // On a tie the port that did not win last time is granted.
                // rst_n gating keeps ready low during reset when the reset state is RUN.
                a_ready = rst_n & bus.a_valid & (~bus.b_valid | (last_grant_q == GrantB));
                b_ready = rst_n & bus.b_valid & (~bus.a_valid | (last_grant_q == GrantA));
                if (a_ready) begin
                    last_grant_d = GrantA;
                    // Register 0 is hardwired zero: accept but suppress the write
                    if (bus.a_addr != '0) begin
                        we3_d = 1'b1;
                        wa3_d = bus.a_addr;
                        wd3_d = bus.a_data;
                    end
                end else if (b_ready) begin
                    last_grant_d = GrantB;
                    if (bus.b_addr != '0) begin
                        we3_d = 1'b1;
                        wa3_d = bus.b_addr;
                        wd3_d = bus.b_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GrantB;
            clr_cnt_q    <= '0;
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            init_done_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            clr_cnt_q    <= clr_cnt_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            init_done_q  <= init_done_d;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.WE3       = we3_q;
    assign bus.WA3       = wa3_q;
    assign bus.WD3       = wd3_q;
    assign bus.init_done = init_done_q;

endmodule
